// File: rtl/mem_port_arbiter_if.sv
// Bundle of request, response and memory-side signals for mem_port_arbiter.
// The arbiter uses the slave modport; requesters plus memory use the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              owner;
  logic              if_stall;
  logic              mem_stall;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           owner, if_stall, mem_stall
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           owner, if_stall, mem_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between fetch refill and data accesses.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              grant_s;
  logic              pick_data_s;
  logic              owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0] starve_q, starve_d;
`else
  localparam int unused_starve_max = STARVE_MAX;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) state_d = ISSUE;
        else                        state_d = IDLE;
      end
      ISSUE, WAIT: begin
        if (bus.mem_valid) state_d = DONE;
        else               state_d = WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data wins ties unless the guard has seen too many data grants in a row.
  always_comb begin
    grant_s = (state_q == IDLE) && (bus.i_req || bus.d_req);
`ifdef ARB_STARVE_GUARD_EN
    if (bus.d_req && bus.i_req && (starve_q == STARVE_LIM)) pick_data_s = 1'b0;
    else                                                     pick_data_s = bus.d_req;
`else
    pick_data_s = bus.d_req;
`endif
  end

  always_comb begin
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    mem_en_d  = (state_d == ISSUE);
    i_ack_d   = (state_d == DONE) && !owner_q;
    d_ack_d   = (state_d == DONE) && owner_q;
    if (grant_s) begin
      owner_d  = pick_data_s;
      addr_d   = pick_data_s ? bus.d_addr : bus.i_addr;
      wdata_d  = pick_data_s ? bus.d_wdata : {DATA_W{1'b0}};
      mem_we_d = pick_data_s && bus.d_we;
    end else if (state_d == WAIT) begin
      mem_we_d = mem_we_q;
    end else begin
      mem_we_d = 1'b0;
    end
    // Read data lands in the owner's register; writes leave it untouched.
    if ((state_q == ISSUE || state_q == WAIT) && bus.mem_valid && !mem_we_q) begin
      if (owner_q) d_rdata_d = bus.mem_rdata;
      else         i_rdata_d = bus.mem_rdata;
    end else begin
      d_rdata_d = d_rdata_q;
    end
`ifdef ARB_STARVE_GUARD_EN
    starve_d = starve_q;
    if (grant_s && !pick_data_s) begin
      starve_d = {CNT_W{1'b0}};
    end else if (grant_s && bus.i_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q   <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      i_rdata_q <= {DATA_W{1'b0}};
      d_rdata_q <= {DATA_W{1'b0}};
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q  <= {CNT_W{1'b0}};
`endif
    end else begin
      owner_q   <= owner_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q  <= starve_d;
`endif
    end
  end

  assign bus.owner     = owner_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_stall  = bus.i_req & ~i_ack_q;
  assign bus.mem_stall = bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, reset abandon and starvation.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   g;
  logic exp_owner [6];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_mem_en"},    64'(bus.mem_en),    64'd0);
    check_val({pfx, "_mem_we"},    64'(bus.mem_we),    64'd0);
    check_val({pfx, "_i_ack"},     64'(bus.i_ack),     64'd0);
    check_val({pfx, "_d_ack"},     64'(bus.d_ack),     64'd0);
    check_val({pfx, "_owner"},     64'(bus.owner),     64'd0);
    check_val({pfx, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
    check_val({pfx, "_mem_wdata"}, bus.mem_wdata,      64'd0);
    check_val({pfx, "_i_rdata"},   bus.i_rdata,        64'd0);
    check_val({pfx, "_d_rdata"},   bus.d_rdata,        64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req = 1'b0; bus.i_addr = 16'h0000;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'h0000; bus.d_wdata = 64'd0;
    bus.mem_rdata = 64'd0; bus.mem_valid = 1'b0;
    rst = 1'b0;
    tick(); tick();
    check_all_zero("rst");
    rst = 1'b1;
    tick();

    // Single fetch, L = 2.
    bus.i_req = 1'b1; bus.i_addr = 16'h0040; #1;
    check_val("f_t_stall", 64'(bus.if_stall), 64'd1);
    check_val("f_t_en",    64'(bus.mem_en),   64'd0);
    tick();
    check_val("f_t1_en",    64'(bus.mem_en),   64'd1);
    check_val("f_t1_addr",  64'(bus.mem_addr), 64'h0040);
    check_val("f_t1_we",    64'(bus.mem_we),   64'd0);
    check_val("f_t1_owner", 64'(bus.owner),    64'd0);
    check_val("f_t1_stall", 64'(bus.if_stall), 64'd1);
    tick();
    check_val("f_t2_en",   64'(bus.mem_en),   64'd0);
    check_val("f_t2_addr", 64'(bus.mem_addr), 64'h0040);
    tick();
    bus.mem_valid = 1'b1; bus.mem_rdata = 64'h1111_2222_3333_4444;
    check_val("f_t3_ack",   64'(bus.i_ack),    64'd0);
    check_val("f_t3_stall", 64'(bus.if_stall), 64'd1);
    tick();
    bus.mem_valid = 1'b0; #1;
    check_val("f_t4_ack",   64'(bus.i_ack),    64'd1);
    check_val("f_t4_rdata", bus.i_rdata,       64'h1111_2222_3333_4444);
    check_val("f_t4_stall", 64'(bus.if_stall), 64'd0);
    check_val("f_t4_dack",  64'(bus.d_ack),    64'd0);
    tick();
    bus.i_req = 1'b0;
    check_val("f_t5_ack", 64'(bus.i_ack), 64'd0);

    // Data write, L = 1.
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h8000; bus.d_wdata = 64'h0000_0000_0000_AAAA; #1;
    check_val("w_t_stall", 64'(bus.mem_stall), 64'd1);
    tick();
    check_val("w_t1_en",    64'(bus.mem_en),    64'd1);
    check_val("w_t1_we",    64'(bus.mem_we),    64'd1);
    check_val("w_t1_addr",  64'(bus.mem_addr),  64'h8000);
    check_val("w_t1_wdata", bus.mem_wdata,      64'h0000_0000_0000_AAAA);
    check_val("w_t1_owner", 64'(bus.owner),     64'd1);
    tick();
    bus.mem_valid = 1'b1; bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    check_val("w_t2_en", 64'(bus.mem_en), 64'd0);
    check_val("w_t2_we", 64'(bus.mem_we), 64'd1);
    tick();
    bus.mem_valid = 1'b0; #1;
    check_val("w_t3_ack",   64'(bus.d_ack),     64'd1);
    check_val("w_t3_rdata", bus.d_rdata,        64'd0);
    check_val("w_t3_stall", 64'(bus.mem_stall), 64'd0);
    check_val("w_t3_iack",  64'(bus.i_ack),     64'd0);
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    check_val("w_t4_ack", 64'(bus.d_ack), 64'd0);

    // Simultaneous requests: data first (L = 1), then fetch (L = 0).
    tick();
    bus.d_req = 1'b1; bus.d_addr = 16'h0100; bus.i_req = 1'b1; bus.i_addr = 16'h0200;
    tick();
    check_val("p_t1_owner", 64'(bus.owner),    64'd1);
    check_val("p_t1_addr",  64'(bus.mem_addr), 64'h0100);
    tick();
    bus.mem_valid = 1'b1; bus.mem_rdata = 64'h0D0D_0D0D_0D0D_0D0D;
    tick();
    bus.mem_valid = 1'b0; #1;
    check_val("p_t3_dack",   64'(bus.d_ack),     64'd1);
    check_val("p_t3_drdata", bus.d_rdata,        64'h0D0D_0D0D_0D0D_0D0D);
    check_val("p_t3_iack",   64'(bus.i_ack),     64'd0);
    check_val("p_t3_istall", 64'(bus.if_stall),  64'd1);
    tick();
    bus.d_req = 1'b0;
    check_val("p_t4_en",   64'(bus.mem_en), 64'd0);
    check_val("p_t4_dack", 64'(bus.d_ack),  64'd0);
    tick();
    check_val("p_t5_en",    64'(bus.mem_en),   64'd1);
    check_val("p_t5_owner", 64'(bus.owner),    64'd0);
    check_val("p_t5_addr",  64'(bus.mem_addr), 64'h0200);
    bus.mem_valid = 1'b1; bus.mem_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
    tick();
    bus.mem_valid = 1'b0; #1;
    check_val("z_t2_iack",   64'(bus.i_ack), 64'd1);
    check_val("z_t2_irdata", bus.i_rdata,    64'h0F0F_0F0F_0F0F_0F0F);
    check_val("z_t2_drdata", bus.d_rdata,    64'h0D0D_0D0D_0D0D_0D0D);
    tick();
    bus.i_req = 1'b0;

    // Spurious mem_valid while idle.
    tick();
    bus.mem_valid = 1'b1; bus.mem_rdata = 64'h5555_5555_5555_5555;
    tick();
    bus.mem_valid = 1'b0; #1;
    check_val("s_iack",   64'(bus.i_ack),  64'd0);
    check_val("s_dack",   64'(bus.d_ack),  64'd0);
    check_val("s_en",     64'(bus.mem_en), 64'd0);
    tick();
    check_val("s_iack2",  64'(bus.i_ack),  64'd0);
    check_val("s_dack2",  64'(bus.d_ack),  64'd0);
    check_val("s_irdata", bus.i_rdata,     64'h0F0F_0F0F_0F0F_0F0F);

    // Reset while waiting abandons the access.
    bus.i_req = 1'b1; bus.i_addr = 16'h0300;
    tick();
    check_val("r_t1_en", 64'(bus.mem_en), 64'd1);
    tick();
    rst = 1'b0; bus.i_req = 1'b0;
    tick();
    rst = 1'b1; #1;
    check_all_zero("r_post");
    tick();
    tick();
    bus.mem_valid = 1'b1; bus.mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    tick();
    bus.mem_valid = 1'b0; #1;
    check_all_zero("r_late");
    tick();
    check_val("r_late_iack2", 64'(bus.i_ack), 64'd0);
    check_val("r_late_dack2", 64'(bus.d_ack), 64'd0);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0010;
    tick();
    check_val("r_n_en",    64'(bus.mem_en),   64'd1);
    check_val("r_n_owner", 64'(bus.owner),    64'd1);
    check_val("r_n_addr",  64'(bus.mem_addr), 64'h0010);
    tick();
    bus.mem_valid = 1'b1; bus.mem_rdata = 64'h0000_0000_0000_0055;
    tick();
    bus.mem_valid = 1'b0; #1;
    check_val("r_n_ack",   64'(bus.d_ack), 64'd1);
    check_val("r_n_rdata", bus.d_rdata,    64'h0000_0000_0000_0055);
    tick();
    bus.d_req = 1'b0;
    tick();

    // Both requests held continuously; memory answers in the issue cycle.
`ifdef ARB_STARVE_GUARD_EN
    exp_owner[0] = 1'b1; exp_owner[1] = 1'b1; exp_owner[2] = 1'b1;
    exp_owner[3] = 1'b0; exp_owner[4] = 1'b1; exp_owner[5] = 1'b1;
`else
    for (int k = 0; k < 6; k++) exp_owner[k] = 1'b1;
`endif
    bus.i_req = 1'b1; bus.i_addr = 16'h0400;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
    bus.mem_rdata = 64'h0000_0000_0000_0077;
    g = 0;
    for (int cyc = 0; cyc < 80 && g < 6; cyc++) begin
      tick();
      if (bus.mem_en) begin
        check_val($sformatf("starve_owner%0d", g), 64'(bus.owner), 64'(exp_owner[g]));
        g++;
        bus.mem_valid = 1'b1;
      end else begin
        bus.mem_valid = 1'b0;
      end
    end
    check_val("starve_grants", 64'(g), 64'd6);
    tick();
    bus.mem_valid = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick();
    tick();
    check_val("end_en", 64'(bus.mem_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch cache refill path (`mem_req_type` from the IF stage) and the data path of the MEM stage. It arbitrates between the two, sequences each access through issue, wait and acknowledge phases, and returns read data to the winner. It also drives the pipeline stall signals that hold IF and MEM while their access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 16: address width of both requesters and the memory port.
- `DATA_W`, 64: access width, one 4×16-bit cache line.
- `STARVE_MAX`, 3: consecutive data grants allowed while a fetch is waiting. Used only with the starvation guard.

Ports:
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `i_req`, input, 1: fetch refill request; held until `i_ack`.
- `i_addr`, input, ADDR_W: fetch line address; stable while `i_req` is high.
- `i_ack`, output, 1: one-cycle pulse; `i_rdata` is valid in that cycle.
- `i_rdata`, output, DATA_W: registered refill data.
- `d_req`, input, 1: data request; held until `d_ack`.
- `d_we`, input, 1: 1 = write, 0 = read.
- `d_addr`, input, ADDR_W: data address; stable while `d_req` is high.
- `d_wdata`, input, DATA_W: write data.
- `d_ack`, output, 1: one-cycle completion pulse.
- `d_rdata`, output, DATA_W: registered read data.
- `mem_en`, output, 1: one-cycle issue strobe to memory.
- `mem_we`, output, 1: write enable, qualified by `mem_en`.
- `mem_addr`, output, ADDR_W: memory address.
- `mem_wdata`, output, DATA_W: memory write data.
- `mem_rdata`, input, DATA_W: memory read data, valid with `mem_valid`.
- `mem_valid`, input, 1: completion pulse from memory, for reads and writes.
- `owner`, output, 1: 0 = fetch owns the port, 1 = data owns the port. Meaningful only while not IDLE.
- `if_stall`, output, 1: combinational, `i_req & ~i_ack`.
- `mem_stall`, output, 1: combinational, `d_req & ~d_ack`.

## Operation
State machine states: IDLE, ISSUE, WAIT, DONE.

- **IDLE → ISSUE** when either request is high. The winner is latched into `owner`; its address, write enable and write data are captured into registers.
- **ISSUE** (one cycle): `mem_en` = 1, and `mem_we`/`mem_addr`/`mem_wdata` are driven from the captured registers.
  - If `mem_valid` is already high in this cycle, go to DONE.
  - Otherwise go to WAIT.
- **WAIT**: hold `mem_addr`/`mem_we`/`mem_wdata` with `mem_en` = 0. When `mem_valid` = 1, capture `mem_rdata` into the owner's rdata register and go to DONE.
- **DONE** (one cycle): pulse the owner's ack, then go to IDLE.
  - Requests are not sampled in DONE.
  - The requester deasserts or changes its request on the edge that ends the ack cycle.
- Priority: data beats fetch when both are pending in IDLE, subject to the starvation guard (see Configuration).
- Writes: the write ack is also pulsed in DONE. `d_rdata` is not updated on a write.
- `mem_valid` is ignored in IDLE and DONE; a spurious pulse there has no effect.

## Timing
- Reset (`rst` = 0 at a rising edge) forces:
  - state to IDLE;
  - `mem_en`, `mem_we`, `i_ack`, `d_ack`, `owner` to 0;
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` to 0;
  - starvation counter to 0.
- Reset mid-access abandons the access. A late `mem_valid` after reset is ignored because the block is in IDLE.
- Latency, with a request first seen in IDLE at cycle t and memory latency L ≥ 1:
  - `mem_en` at t+1;
  - `mem_valid` at t+1+L;
  - ack at t+2+L.
- Memory answering in the issue cycle (L = 0) gives ack at t+2.
- Back-to-back accesses: the next arbitration happens in the IDLE cycle at ack+1. The minimum spacing between `mem_en` strobes is L+3 cycles.
- `if_stall` and `mem_stall` are high from request assertion through the cycle before the ack, and low in the ack cycle.

## Configuration
`ARB_STARVE_GUARD_EN`:
- **Defined:** a counter, saturating at `STARVE_MAX`, increments on each data grant made while `i_req` = 1 and clears on every fetch grant. When the counter equals `STARVE_MAX` and both requests are pending, fetch wins.
- **Undefined:** strict data priority and no counter.

## Test plan
- Single fetch, `i_addr` = 0x0040, memory returns 0x1111_2222_3333_4444 after L = 2 → `mem_en` at t+1; `i_ack` at t+4 with that data; `if_stall` high for cycles t..t+3.
- Data write, `d_addr` = 0x8000, `d_wdata` = 0xAAAA, L = 1 → `mem_we` = 1 with `mem_addr` = 0x8000 at t+1; `d_ack` at t+3; `d_rdata` stays 0.
- `i_req` and `d_req` raised in the same cycle → data is granted first (`owner` = 1); fetch is granted in the IDLE cycle after `d_ack`.
- With `ARB_STARVE_GUARD_EN` and `STARVE_MAX` = 3, `d_req` kept pending continuously and `i_req` held → exactly 3 data grants, then 1 fetch grant, then data again. Without the macro, fetch is never granted while `d_req` stays high.
- `rst` driven low while in WAIT, then `mem_valid` pulsed 2 cycles after release → no ack is produced, all outputs are 0, and the next request proceeds normally.
- `mem_valid` in the ISSUE cycle (L = 0) → ack at t+2; a spurious `mem_valid` in IDLE produces no ack.
